multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences each instruction over 3-5 states.
- Generates datapath strobes per state and waits on a memory ready handshake.
- Adds addi and j to the existing R-type/lw/sw/beq/lui set, plus memory timeout and illegal-opcode detection.
- Sits between the instruction register's op field and the shared-memory multi-cycle datapath.

Parameters:
OP_WIDTH, 6, opcode field width
STATE_W, 4, width of exported state code
TIMEOUT, 15, max cycles waiting for mem_ready in a memory state; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
op  in  OP_WIDTH  opcode from instruction register
mem_ready  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  1=MDR to register file
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
ALUctr  out  2  00=add, 01=sub, 10=funct decode, 11=lui (imm<<16)
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  STATE_W  current state code
illegal  out  1  one-cycle pulse on unsupported opcode
mem_err  out  1  one-cycle pulse on memory timeout
instr_done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Only clk/rst. State register and pulse flags update on rising clk. Strobes decode combinationally from state, plus mem_ready where noted. Any strobe not listed for a state is 0.
- Reset: state=IDLE(0). All outputs 0 while rst is high and in IDLE, including illegal, mem_err, instr_done and the wait counter. IDLE -> FETCH unconditionally.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, lui=001111, addi=001000, j=000010. Any other opcode is illegal.
- FETCH(1):
  - Strobes: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUctr=00. Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - addi/lui -> IEXEC
  - j -> JUMP
  - illegal -> FETCH, with illegal=1 next cycle
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUctr=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD(4): MemRead=1, IorD=1. Wait for mem_ready, then -> MEMWB.
- MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR(6): MemWrite=1, IorD=1. Wait for mem_ready, then -> FETCH.
- EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUctr=10 -> RWB.
- RWB(8): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUctr=01, PCWriteCond=1, PCSource=01 -> FETCH.
- IEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUctr=00 for addi, 11 for lui -> IWB. op is sampled in IEXEC; the IR is stable.
- IWB(11): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- JUMP(12): PCWrite=1, PCSource=10 -> FETCH.
- instr_done: registered pulse in the cycle after leaving MEMWB, MEMWR (on ready), RWB, BRANCH, IWB or JUMP. Not asserted for illegal opcodes or timeouts.
- Latencies from FETCH entry, with 0-wait memory: R/addi/lui = 4 cycles, lw = 5, sw = 4, beq = 3, j = 3.
- Timeout (TIMEOUT>0):
  - The wait counter increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0, and clears on any state change.
  - When the counter = TIMEOUT-1 and mem_ready=0: go to FETCH and pulse mem_err next cycle. No IRWrite, PCWrite, RegWrite or MemWrite is issued for the aborted access.
  - mem_ready=1 in the timeout cycle wins: normal transition, no mem_err.
  - A timeout in FETCH re-enters FETCH with the counter cleared (retry).
- Timeout disabled (TIMEOUT=0): the counter is held at 0 and waits are unbounded.
- Reset asserted mid-instruction: the next state is IDLE regardless of state or mem_ready. Pending pulses are cleared and no strobe is asserted in the IDLE cycle.
- Unused state codes (13-15): behave as IDLE (all outputs 0) and go to FETCH.

Test Plan:
- Reset, then R-type (op=000000), mem_ready=1 constantly -> states 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. instr_done pulses once.
- lw (100011) with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles. MemRead=1 and IorD=1 throughout. MEMWB shows MemtoReg=1, RegWrite=1.
- sw, beq, j, lui, addi back-to-back with ready=1:
  - sw: MemWrite=1 for 1 cycle.
  - beq: PCWriteCond=1, ALUctr=01, PCSource=01.
  - j: PCWrite=1, PCSource=10.
  - lui: ALUctr=11 in IEXEC. addi: ALUctr=00 in IEXEC.
- op=111111 in DECODE -> returns to FETCH. illegal=1 for exactly 1 cycle. RegWrite, MemWrite and instr_done stay 0.
- TIMEOUT=15, mem_ready held 0 in MEMWR -> after 15 cycles state=FETCH and mem_err=1 for 1 cycle, with no MemWrite afterwards. Repeat with TIMEOUT=0 -> waits 40 cycles, no mem_err.
- Assert rst during MEMRD with mem_ready=1 -> next state=0, all outputs 0, then FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the shared-memory datapath.
// The controller drives through the master modport; the datapath/memory side uses slave.
interface multicycle_control_if #(
    parameter int OP_WIDTH = 6,
    parameter int STATE_W  = 4
);
    // Memory handshake: MemRead/MemWrite is the request (valid), mem_ready the
    // completion (ready). An access completes in the cycle where both are high;
    // the request is held, and the address source stays fixed, until then.
    logic [OP_WIDTH-1:0] op;
    logic                mem_ready;

    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUctr;
    logic [1:0]          PCSource;

    logic [STATE_W-1:0]  state;
    logic                illegal;
    logic                mem_err;
    logic                instr_done;

    modport master (
        input  op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUctr, PCSource,
               state, illegal, mem_err, instr_done
    );

    modport slave (
        output op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUctr, PCSource,
               state, illegal, mem_err, instr_done
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: one state per datapath step, Moore strobes
// except FETCH's IRWrite/PCWrite, with memory wait timeout and illegal-op detection.
module multicycle_control #(
    parameter int OP_WIDTH = 6,
    parameter int STATE_W  = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BRANCH = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'b001111);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           stateReg;
    state_t           stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic             illegalQ;
    logic             memErrQ;
    logic             doneQ;

    logic             waitState;
    logic             timeoutHit;
    logic             opIllegal;
    logic             retire;

    always_comb begin
        opIllegal = 1'b1;
        case (bus.op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_ADDI, OP_J: opIllegal = 1'b0;
            default:                                           opIllegal = 1'b1;
        endcase
    end

    // Only the three memory-facing states can stall; ready in the last allowed cycle wins.
    always_comb begin
        waitState  = (stateReg == FETCH) || (stateReg == MEMRD) || (stateReg == MEMWR);
        timeoutHit = (TIMEOUT > 0) && waitState && !bus.mem_ready && (waitCnt == CNT_LAST);
    end

    always_comb begin
        stateNext       = stateReg;
        retire          = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUctr      = 2'b00;
        bus.PCSource    = 2'b00;

        case (stateReg)
            IDLE: stateNext = FETCH;

            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready) stateNext = DECODE;
            end

            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW:    stateNext = MEMADR;
                    OP_R:            stateNext = EXEC;
                    OP_BEQ:          stateNext = BRANCH;
                    OP_ADDI, OP_LUI: stateNext = IEXEC;
                    OP_J:            stateNext = JUMP;
                    default:         stateNext = FETCH;
                endcase
            end

            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                stateNext   = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end

            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready)  stateNext = MEMWB;
                else if (timeoutHit) stateNext = FETCH;
            end

            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                stateNext    = FETCH;
                retire       = 1'b1;
            end

            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    stateNext = FETCH;
                    retire    = 1'b1;
                end else if (timeoutHit) begin
                    stateNext = FETCH;
                end
            end

            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUctr  = 2'b10;
                stateNext   = RWB;
            end

            RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                stateNext    = FETCH;
                retire       = 1'b1;
            end

            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUctr      = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                stateNext       = FETCH;
                retire          = 1'b1;
            end

            IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUctr  = (bus.op == OP_LUI) ? 2'b11 : 2'b00;
                stateNext   = IWB;
            end

            IWB: begin
                bus.RegWrite = 1'b1;
                stateNext    = FETCH;
                retire       = 1'b1;
            end

            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                stateNext    = FETCH;
                retire       = 1'b1;
            end

            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            waitCnt  <= '0;
            illegalQ <= 1'b0;
            memErrQ  <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            illegalQ <= (stateReg == DECODE) && opIllegal;
            memErrQ  <= timeoutHit;
            doneQ    <= retire;
            // A FETCH timeout keeps the state but must restart the count for the retry.
            if ((TIMEOUT == 0) || !waitState || bus.mem_ready || timeoutHit ||
                (stateNext != stateReg))
                waitCnt <= '0;
            else
                waitCnt <= waitCnt + 1'b1;
        end
    end

    assign bus.state      = STATE_W'(stateReg);
    assign bus.illegal    = illegalQ;
    assign bus.mem_err    = memErrQ;
    assign bus.instr_done = doneQ;

    a_mem_excl : assert property (@(posedge clk) disable iff (rst)
        !(bus.MemRead && bus.MemWrite));
    a_pulse_excl : assert property (@(posedge clk) disable iff (rst)
        $onehot0({illegalQ, memErrQ, doneQ}));

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model feeding a
// per-cycle expected-output queue, checked by an independent monitor.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam int TMO_A = 15;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                   S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_BRANCH = 9,
                   S_IEXEC = 10, S_IWB = 11, S_JUMP = 12;

    // clock / reset
    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    always #5 clk = ~clk;

    multicycle_control_if #(.OP_WIDTH(6), .STATE_W(4)) ifA ();
    multicycle_control_if #(.OP_WIDTH(6), .STATE_W(4)) ifB ();

    multicycle_control #(.OP_WIDTH(6), .STATE_W(4), .TIMEOUT(TMO_A)) dutA (
        .clk(clk), .rst(rstA), .bus(ifA.master));
    multicycle_control #(.OP_WIDTH(6), .STATE_W(4), .TIMEOUT(0)) dutB (
        .clk(clk), .rst(rstB), .bus(ifB.master));

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,ALUSrcB,ALUctr,PCSource,state,illegal,mem_err,instr_done}
    wire [22:0] obsA = {ifA.PCWrite, ifA.PCWriteCond, ifA.IorD, ifA.MemRead, ifA.MemWrite,
                        ifA.IRWrite, ifA.MemtoReg, ifA.RegDst, ifA.RegWrite, ifA.ALUSrcA,
                        ifA.ALUSrcB, ifA.ALUctr, ifA.PCSource, ifA.state,
                        ifA.illegal, ifA.mem_err, ifA.instr_done};
    wire [22:0] obsB = {ifB.PCWrite, ifB.PCWriteCond, ifB.IorD, ifB.MemRead, ifB.MemWrite,
                        ifB.IRWrite, ifB.MemtoReg, ifB.RegDst, ifB.RegWrite, ifB.ALUSrcA,
                        ifB.ALUSrcB, ifB.ALUctr, ifB.PCSource, ifB.state,
                        ifB.illegal, ifB.mem_err, ifB.instr_done};

    logic [22:0] exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   seenDone  = 0;
    int   expRetire = 0;
    logic useB      = 1'b0;
    logic doFinal   = 1'b0;
    logic pendIll   = 1'b0;
    logic pendErr   = 1'b0;
    logic pendDone  = 1'b0;
    logic [5:0] curOp = 6'h00;

    // Expected strobes of one cycle, straight from the per-state strobe table.
    function automatic logic [22:0] strobes(input int st, input logic [5:0] o, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, actr, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; actr = 2'b00; psrc = 2'b00;
        case (st)
            S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mr = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mw = 1; iord = 1; end
            S_EXEC:   begin asa = 1; actr = 2'b10; end
            S_RWB:    begin rw = 1; rd = 1; end
            S_BRANCH: begin asa = 1; actr = 2'b01; pcwc = 1; psrc = 2'b01; end
            S_IEXEC:  begin asa = 1; asb = 2'b10; actr = (o == OP_LUI) ? 2'b11 : 2'b00; end
            S_IWB:    rw = 1;
            S_JUMP:   begin pcw = 1; psrc = 2'b10; end
            default:  ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, actr, psrc,
                4'(st), 3'b000};
    endfunction

    function automatic int kind(input logic [5:0] o);
        case (o)
            OP_R:            return 0;
            OP_LW:           return 1;
            OP_SW:           return 2;
            OP_BEQ:          return 3;
            OP_LUI, OP_ADDI: return 4;
            OP_J:            return 5;
            default:         return -1;
        endcase
    endfunction

    // driver: one clock cycle of stimulus plus its expected outputs
    task automatic step(input int st, input logic rdy);
        logic [22:0] e;
        ifA.mem_ready = rdy; ifB.mem_ready = rdy;
        ifA.op = curOp;      ifB.op = curOp;
        e = strobes(st, curOp, rdy);
        e[2:0] = {pendIll, pendErr, pendDone};
        pendIll = 0; pendErr = 0; pendDone = 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step_any(input int st);
        step(st, 1'($urandom_range(0, 1)));
    endtask

    // A memory-facing state: `waits` not-ready cycles then ready, unless the timeout fires.
    task automatic wait_phase(input int st, input int waits, output bit ok);
        int cnt = 0;
        int tmo = useB ? 0 : TMO_A;
        ok = 1;
        for (int i = 0; i <= waits; i++) begin
            if (i != waits && tmo > 0 && cnt == tmo - 1) begin
                step(st, 1'b0);
                pendErr = 1;
                cnt = 0;
                if (st != S_FETCH) begin
                    ok = 0;
                    return;
                end
            end else begin
                step(st, i == waits);
                cnt++;
            end
        end
    endtask

    task automatic retire_now();
        pendDone = 1;
        expRetire++;
    endtask

    task automatic run_instr(input logic [5:0] o, input int fetchWaits, input int memWaits);
        bit ok;
        curOp = o;
        wait_phase(S_FETCH, fetchWaits, ok);
        step_any(S_DECODE);
        case (kind(o))
            0: begin step_any(S_EXEC); step_any(S_RWB); retire_now(); end
            1: begin
                step_any(S_MEMADR);
                wait_phase(S_MEMRD, memWaits, ok);
                if (ok) begin step_any(S_MEMWB); retire_now(); end
            end
            2: begin
                step_any(S_MEMADR);
                wait_phase(S_MEMWR, memWaits, ok);
                if (ok) retire_now();
            end
            3: begin step_any(S_BRANCH); retire_now(); end
            4: begin step_any(S_IEXEC); step_any(S_IWB); retire_now(); end
            5: begin step_any(S_JUMP); retire_now(); end
            default: pendIll = 1;
        endcase
    endtask

    task automatic random_instrs(input int n, input bit longWaits);
        logic [5:0] ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_ADDI, OP_J};
        for (int k = 0; k < n; k++) begin
            int sel = $urandom_range(0, 8);
            logic [5:0] o = (sel < 7) ? ops[sel] : 6'($urandom_range(0, 63));
            int fw = ($urandom_range(0, 7) == 0 && longWaits) ? $urandom_range(13, 16)
                                                               : $urandom_range(0, 2);
            int mw = ($urandom_range(0, 4) == 0 && longWaits) ? $urandom_range(13, 16)
                                                               : $urandom_range(0, 3);
            run_instr(o, fw, mw);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [22:0] expV;
        logic [22:0] obs;
        if (exp_q.size() != 0) begin
            expV = exp_q.pop_front();
            obs  = useB ? obsB : obsA;
            checks++;
            if (obs !== expV) begin
                errors++;
                $display("FAIL out_vec t=%0t dut=%s exp_state=%0d got_state=%0d got=%h exp=%h",
                         $time, useB ? "B" : "A", expV[6:3], obs[6:3], obs, expV);
            end
            if (obs[0] === 1'b1) seenDone++;
        end
        if (doFinal) begin
            doFinal = 1'b0;
            checks++;
            if (seenDone != expRetire) begin
                errors++;
                $display("FAIL retire_count got=%0d exp=%0d", seenDone, expRetire);
            end
        end
    end

    initial begin
        bit ok;
        rstA = 1; rstB = 1;
        ifA.op = '0; ifB.op = '0; ifA.mem_ready = 0; ifB.mem_ready = 0;
        repeat (3) @(posedge clk);
        #1;

        // DUT A: TIMEOUT = 15
        step(S_IDLE, 1'b0);
        rstA = 0;
        step_any(S_IDLE);
        run_instr(OP_R, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_LUI, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(OP_SW, 0, 40);
        run_instr(OP_LW, 0, 14);
        run_instr(OP_LW, 0, 15);
        run_instr(OP_R, 20, 0);

        curOp = OP_LW;
        wait_phase(S_FETCH, 0, ok);
        step_any(S_DECODE);
        step_any(S_MEMADR);
        rstA = 1;
        step(S_MEMRD, 1'b1);
        rstA = 0;
        step_any(S_IDLE);
        random_instrs(60, 1'b1);

        rstA = 1;
        step(S_FETCH, 1'b0);

        // DUT B: timeout disabled
        useB = 1;
        step(S_IDLE, 1'b0);
        rstB = 0;
        step_any(S_IDLE);
        run_instr(OP_SW, 0, 40);
        run_instr(OP_R, 0, 0);
        run_instr(OP_LW, 2, 20);
        random_instrs(12, 1'b1);
        step(S_FETCH, 1'b0);

        doFinal = 1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
